// File: rtl/fxp_pkg.sv
// Shared types, widths and the saturating clip helper for the fixed-point requantizer paths.
package fxp_pkg;

  localparam int W_IN   = 29;
  localparam int W_OUT  = 16;
  localparam int W_FRAC = 8;
  localparam int W_V    = W_IN + W_OUT + 1;

  typedef logic signed [W_IN-1:0]   prod_t;
  typedef logic        [W_FRAC-1:0] frac_t;
  typedef logic signed [W_V-1:0]    wide_t;

  typedef struct packed {
    logic             sat;
    logic [W_OUT-1:0] data;
  } clip_t;

  localparam wide_t WIDE_ONE = {{(W_V-1){1'b0}}, 1'b1};

  // Clamp a wide signed value into a signed field of 'width' bits (width <= W_OUT).
  function automatic clip_t sat_clip(input wide_t value, input int width);
    wide_t lim;
    wide_t max_v;
    wide_t min_v;
    clip_t res;
    lim   = WIDE_ONE <<< (width - 32'sd1);
    max_v = lim - WIDE_ONE;
    min_v = -lim;
    if (value > max_v) begin
      res.sat  = 1'b1;
      res.data = max_v[W_OUT-1:0];
    end else if (value < min_v) begin
      res.sat  = 1'b1;
      res.data = min_v[W_OUT-1:0];
    end else begin
      res.sat  = 1'b0;
      res.data = value[W_OUT-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/fxp_pipe_reg.sv
// Valid/ready register slice: holds one payload beat and stalls it while downstream is not ready.
module fxp_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_r;
  logic [W-1:0] data_r;

  assign in_ready  = !valid_r || out_ready;
  assign out_valid = valid_r;
  assign out_data  = data_r;

  // Load a new beat whenever the slot is empty or being drained this cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_r <= 1'b0;
      data_r  <= '0;
    end else if (in_ready) begin
      valid_r <= in_valid;
      if (in_valid) begin
        data_r <= in_data;
      end
    end
  end

endmodule

// File: rtl/fxp_requant.sv
// Two-stage requantizer: rescale by the fraction-position difference with round-half-up, then saturate.
// Optional saturation counter port sat_count is built when FXP_REQUANT_SATCNT_EN is defined.
module fxp_requant
  import fxp_pkg::*;
(
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [W_IN-1:0]   in_data,
  input  logic        [W_FRAC-1:0] num_frac_in,
  input  logic        [W_FRAC-1:0] num_frac_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [W_OUT-1:0]  out_data,
  output logic                     out_sat
`ifdef FXP_REQUANT_SATCNT_EN
  ,
  output logic        [15:0]       sat_count
`endif
);

  localparam logic signed [W_FRAC:0] SH_ZERO  = '0;
  localparam logic signed [W_FRAC:0] SH_MAX   = (W_FRAC+1)'(W_IN);
  localparam logic        [W_FRAC:0] NSH_SAT  = (W_FRAC+1)'(W_OUT);
  localparam frac_t                  FRAC_ONE = {{(W_FRAC-1){1'b0}}, 1'b1};
  // Any magnitude beyond the output range works as a forced-saturation marker.
  localparam wide_t                  SAT_POS  = WIDE_ONE <<< W_OUT;
  localparam wide_t                  SAT_NEG  = -SAT_POS;

  logic signed [W_FRAC:0] sh_s;
  logic        [W_FRAC:0] nsh_s;
  frac_t                  rsh_s;
  wide_t                  ext_s;
  wide_t                  v_s;
  wide_t                  s1_v_s;
  logic                   s1_valid_s;
  logic                   s2_ready_s;
  clip_t                  clip_s;
  clip_t                  s2_q_s;

  assign sh_s  = $signed({1'b0, num_frac_in}) - $signed({1'b0, num_frac_out});
  assign nsh_s = -sh_s;
  assign rsh_s = sh_s[W_FRAC-1:0];
  assign ext_s = {{(W_V-W_IN){in_data[W_IN-1]}}, in_data};

  // Full-precision rescale of the incoming product into the wide intermediate.
  always_comb begin
    v_s = '0;
    if (sh_s > SH_ZERO) begin
      if (sh_s > SH_MAX) begin
        v_s = '0;
      end else begin
        v_s = (ext_s + (WIDE_ONE <<< (rsh_s - FRAC_ONE))) >>> rsh_s;
      end
    end else if (sh_s == SH_ZERO) begin
      v_s = ext_s;
    end else begin
      if (in_data == '0) begin
        v_s = '0;
      end else if (nsh_s >= NSH_SAT) begin
        v_s = in_data[W_IN-1] ? SAT_NEG : SAT_POS;
      end else begin
        v_s = ext_s <<< nsh_s;
      end
    end
  end

  fxp_pipe_reg #(.W(W_V)) u_s1 (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (v_s),
    .out_valid (s1_valid_s),
    .out_ready (s2_ready_s),
    .out_data  (s1_v_s)
  );

  assign clip_s = sat_clip(s1_v_s, W_OUT);

  fxp_pipe_reg #(.W(W_OUT+1)) u_s2 (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (s1_valid_s),
    .in_ready  (s2_ready_s),
    .in_data   (clip_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_q_s)
  );

  assign out_data = s2_q_s.data;
  assign out_sat  = s2_q_s.sat;

`ifdef FXP_REQUANT_SATCNT_EN
  // Count clipped beats as they leave the block, sticking at all-ones.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sat_count <= 16'h0000;
    end else if (out_valid && out_ready && out_sat && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_fxp_requant.sv
// Directed-vector bench for fxp_requant: table of hand-computed results plus backpressure and reset sequences.
module tb_fxp_requant;

  logic               clk;
  logic               rstn;
  logic               in_valid;
  logic               in_ready;
  logic signed [28:0] in_data;
  logic        [7:0]  num_frac_in;
  logic        [7:0]  num_frac_out;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic               out_sat;
`ifdef FXP_REQUANT_SATCNT_EN
  logic        [15:0] sat_count;
`endif

  fxp_requant dut (
    .clk          (clk),
    .rstn         (rstn),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .num_frac_in  (num_frac_in),
    .num_frac_out (num_frac_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_sat      (out_sat)
`ifdef FXP_REQUANT_SATCNT_EN
    ,
    .sat_count    (sat_count)
`endif
  );

  typedef struct {
    int din;
    int nfi;
    int nfo;
    int exp_d;
    int exp_s;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  int n_vec;
  int n_err;
  int cyc;
  int exp_cnt;
  int got[$];
  int got_cyc[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output handshake; inputs are stable across the coming edge.
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      got.push_back(int'(out_data));
      got_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; exp_cnt = 0;
    vecs[0]  = '{1000, 10, 4, 16, 0};
    vecs[1]  = '{96, 6, 0, 2, 0};
    vecs[2]  = '{-96, 6, 0, -1, 0};
    vecs[3]  = '{95, 6, 0, 1, 0};
    vecs[4]  = '{100000, 0, 0, 32767, 1};
    vecs[5]  = '{-100000, 0, 0, -32768, 1};
    vecs[6]  = '{-5, 2, 5, -40, 0};
    vecs[7]  = '{1, 0, 16, 32767, 1};
    vecs[8]  = '{-7, 40, 0, 0, 0};
    vecs[9]  = '{-268435456, 0, 0, -32768, 1};
    vecs[10] = '{0, 0, 200, 0, 0};
    vecs[11] = '{0, 200, 0, 0, 0};
    vecs[12] = '{32767, 0, 0, 32767, 0};
    vecs[13] = '{-32768, 0, 0, -32768, 0};
    vecs[14] = '{32768, 0, 0, 32767, 1};
    vecs[15] = '{1, 0, 15, 32767, 1};
    vecs[16] = '{-1, 0, 15, -32768, 0};
    vecs[17] = '{3, 1, 0, 2, 0};
    vecs[18] = '{268435455, 29, 0, 0, 0};
    vecs[19] = '{-1, 255, 0, 0, 0};
    vecs[20] = '{-1, 0, 255, -32768, 1};

    // Reset state
    rstn = 1'b0; in_valid = 1'b0; in_data = '0;
    num_frac_in = '0; num_frac_out = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_sat", int'(out_sat), 0);
`ifdef FXP_REQUANT_SATCNT_EN
    chk("rst_sat_count", int'(sat_count), 0);
`endif
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", int'(in_ready), 1);

    // Table: one beat at a time, exact two-cycle latency
    for (int i = 0; i < NV; i++) begin
      in_valid     = 1'b1;
      in_data      = vecs[i].din[28:0];
      num_frac_in  = vecs[i].nfi[7:0];
      num_frac_out = vecs[i].nfo[7:0];
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk($sformatf("vec%0d_early_valid", i), int'(out_valid), 0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), int'(out_valid), 1);
      chk($sformatf("vec%0d_data", i), int'(out_data), vecs[i].exp_d);
      chk($sformatf("vec%0d_sat", i), int'(out_sat), vecs[i].exp_s);
      exp_cnt += vecs[i].exp_s;
    end
    @(posedge clk); #1;
`ifdef FXP_REQUANT_SATCNT_EN
    chk("sat_count_table", int'(sat_count), exp_cnt);
`endif

    // Backpressure: 5 beats against a stalled sink, then drain
    got.delete(); got_cyc.delete();
    num_frac_in = '0; num_frac_out = '0;
    out_ready = 1'b0;
    fork
      begin
        for (int b = 1; b <= 5; b++) begin
          int t;
          t = 0;
          in_valid = 1'b1;
          in_data  = 29'(b);
          @(negedge clk);
          while (!in_ready && t < 40) begin
            @(negedge clk);
            t++;
          end
          if (t >= 40) chk($sformatf("bp_accept_timeout%0d", b), 0, 1);
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 7; c++) begin
          @(negedge clk);
          if (c >= 2) begin
            chk($sformatf("bp_in_ready_c%0d", c), int'(in_ready), 0);
            chk($sformatf("bp_hold_valid_c%0d", c), int'(out_valid), 1);
            chk($sformatf("bp_hold_data_c%0d", c), int'(out_data), 1);
          end
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    begin
      int t;
      t = 0;
      while (got.size() < 5 && t < 30) begin
        @(posedge clk);
        t++;
      end
    end
    chk("bp_count", got.size(), 5);
    for (int k = 0; k < 5; k++) begin
      if (k < got.size()) chk($sformatf("bp_order%0d", k), got[k], k + 1);
      if (k > 0 && k < got.size()) chk($sformatf("bp_rate%0d", k), got_cyc[k] - got_cyc[k-1], 1);
    end

    // Reset with two beats in flight
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 29'sd7;
    @(posedge clk); #1;
    in_data   = 29'sd8;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    chk("mid_full_valid", int'(out_valid), 1);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_data", int'(out_data), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    out_ready = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    got.delete(); got_cyc.delete();
`ifdef FXP_REQUANT_SATCNT_EN
    chk("mid_rst_sat_count", int'(sat_count), 0);
`endif
    in_valid = 1'b1;
    in_data  = 29'sd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("post_rst_early_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    chk("post_rst_valid", int'(out_valid), 1);
    chk("post_rst_data", int'(out_data), 3);
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_beats", got.size(), 1);
    if (got.size() > 0) chk("post_rst_first", got[0], 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fxp_requant.md
Name: fxp_requant

Overview:
- Downstream stage of the fixed-point multiplier top (14b x 14b -> 29b product `c`, fraction position `num_frac_c`).
- Requantizes each signed product to a configurable output word length and fraction position, with round-half-up and saturation.
- Two-stage pipeline with valid/ready handshake, so the word-length optimization flow can sweep output formats per beat.

Parameters:
- W_IN, 29, input word width (signed two's complement).
- W_OUT, 16, output word width (signed two's complement).
- W_FRAC, 8, width of the fraction-position fields.

Ports:
- clk  in  1  clock, all state on rising edge.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  W_IN  signed product.
- num_frac_in  in  W_FRAC  fraction bits of in_data (unsigned), sampled with the beat.
- num_frac_out  in  W_FRAC  requested fraction bits of out_data (unsigned), sampled with the beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_data  out  W_OUT  requantized signed result.
- out_sat  out  1  this beat was clipped.
- sat_count  out  16  only when FXP_REQUANT_SATCNT_EN is defined.

Behaviour:
- Reset: clock is clk; reset is rstn, asynchronous and active-low. Reset clears s1_valid, s2_valid, out_valid, out_data, out_sat and sat_count to 0. in_ready reads 1 once reset is released.
- Shift: sh = signed(num_frac_in) - signed(num_frac_out), computed as a W_FRAC+1-bit signed value.
- Stage 1 (register s1) holds the full-precision value v:
  - sh > 0, rounding add: add 2^(sh-1), then arithmetic right shift by sh (round half toward +inf).
  - sh > 0, bound: if sh > W_IN, v = 0.
  - sh == 0: v = in_data.
  - sh < 0: v = in_data << -sh. Any non-zero in_data with -sh >= W_OUT forces saturation.
  - v is computed at W_IN+W_OUT+1 bits, so no intermediate overflow.
- Stage 2 (register s2):
  - v > 2^(W_OUT-1)-1: out_data = 2^(W_OUT-1)-1 and out_sat = 1.
  - v < -2^(W_OUT-1): out_data = -2^(W_OUT-1) and out_sat = 1.
  - Otherwise out_data = v[W_OUT-1:0] and out_sat = 0.
- Latency: 2 cycles from accept to out_valid with out_ready held high. Throughput is 1 beat/cycle.
- Handshake:
  - s2 loads when (!s2_valid || out_ready).
  - s1 advances when it is empty or s2 loads.
  - in_ready = !s1_valid || (!s2_valid || out_ready). This is a combinational path from out_ready.
  - out_valid, out_data and out_sat stay stable while out_valid && !out_ready.
  - Order is preserved; there is no drop or duplication.
  - At most 2 beats are in flight. With out_ready low and both stages full, in_ready = 0.
- Simultaneous accept and emit in one cycle: the pipeline shifts with no bubble.
- Reset mid-operation: in-flight beats are discarded and out_valid drops immediately (asynchronous).
- Boundary values: in_data = -2^28 with sh = 0 saturates to -32768. in_data = 0 never sets out_sat for any sh.

Optional Feature:
- Macro: FXP_REQUANT_SATCNT_EN.
- When defined: port sat_count[15:0] exists.
  - It increments on each output handshake with out_sat = 1.
  - It saturates at 16'hFFFF and resets to 0.
- When undefined: no port and no counter logic, and the datapath is identical.

Decomposition:
- Package fxp_pkg holds:
  - localparams W_IN = 29, W_OUT = 16, W_FRAC = 8;
  - typedef logic signed [W_IN-1:0] prod_t;
  - typedef logic [W_FRAC-1:0] frac_t;
  - a function sat_clip(value, width) shared with the other requant paths.
- One sub-module: fxp_pipe_reg, a valid/ready register slice carrying payload and valid, instantiated twice for s1 and s2.

Test Plan:
- Basic scale: in_data = 1000, num_frac_in = 10, num_frac_out = 4 (sh = 6), out_ready = 1 -> out_data = 16, out_sat = 0, out_valid exactly 2 cycles after accept.
- Rounding ties: in_data = 96, sh = 6 -> 2; in_data = -96, sh = 6 -> -1; in_data = 95, sh = 6 -> 1.
- Saturation: in_data = 100000, sh = 0 -> 32767 with out_sat = 1; in_data = -100000 -> -32768 with out_sat = 1. With FXP_REQUANT_SATCNT_EN, sat_count = 2 after both beats.
- Left shift and large shift:
  - in_data = -5, num_frac_in = 2, num_frac_out = 5 -> -40.
  - in_data = 1, sh = -16 -> 32767 with out_sat = 1.
  - in_data = -7, sh = 40 -> 0.
- Backpressure: send 5 beats (1..5, sh = 0) with out_ready = 0 for cycles 0-6 -> in_ready = 0 after 2 accepts and the output holds value 1. Then release out_ready -> outputs 1, 2, 3, 4, 5 in order, one per cycle.
- Reset mid-stream: assert rstn = 0 with 2 beats in flight -> out_valid = 0 asynchronously. After release, a new beat in_data = 3, sh = 0 -> out_data = 3 after 2 cycles and no stale beats appear.
